// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared FSM encoding, defaults and index-width helper for the FIFO scheduler
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } sched_state_e;

  localparam int DEFAULT_NUM_CH    = 4;
  localparam int DEFAULT_BURST_LEN = 2;

  // Wide enough for any BURST_LEN up to 15.
  localparam int BURST_CNT_W = 4;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// rtl/fifo_rr_scheduler_rr_pick.sv - combinational masked round-robin priority picker
// Ports:
//   req_i     request vector, one bit per channel
//   ptr_i     round-robin start index; lowest requester >= ptr_i wins, else lowest overall
//   gnt_oh_o  one-hot winner (all zero when no request)
//   gnt_idx_o binary index of the winner (zero when no request)
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int N  = DEFAULT_NUM_CH,
  parameter int IW = ch_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick_vec;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr_i));
    end
  end

  assign masked   = req_i & hi_mask;
  // Fall back to the unmasked vector when nothing sits at or above the pointer (wrap).
  assign pick_vec = (|masked) ? masked : req_i;

  always_comb begin
    gnt_idx_o = '0;
    gnt_oh_o  = '0;
    // Descending scan so the last hit, the lowest index, is kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        gnt_idx_o = IW'(i);
      end
    end
    if (|pick_vec) begin
      gnt_oh_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin burst scheduler draining NUM_CH upstream FIFOs into one output register
// Ports:
//   clk, reset      single clock, asynchronous active-high reset
//   ch_empty        per-FIFO empty flags
//   ch_almost_full  per-FIFO urgency hint (only with FIFO_SCHED_URGENT_EN defined)
//   ch_read_data    registered read data of each FIFO, channel i at [i*W +: W]
//   ch_read         registered one-hot read strobe, high for the single ISSUE cycle
//   out_valid/out_ready/out_data/out_ch  output word handshake and its source channel
// Optional feature macro: FIFO_SCHED_URGENT_EN (urgent channels beat non-urgent ones).
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_CH          = DEFAULT_NUM_CH,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int BURST_LEN       = DEFAULT_BURST_LEN
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 ch_empty,
`ifdef FIFO_SCHED_URGENT_EN
  input  logic [NUM_CH-1:0]                 ch_almost_full,
`endif
  input  logic [NUM_CH*FIFO_DATA_WIDTH-1:0] ch_read_data,
  output logic [NUM_CH-1:0]                 ch_read,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [FIFO_DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]         out_ch
);

  localparam int CW = ch_idx_w(NUM_CH);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  sched_state_e               state_q;
  logic [NUM_CH-1:0]          ch_read_q;
  logic                       out_valid_q;
  logic [FIFO_DATA_WIDTH-1:0] out_data_q;
  logic [CW-1:0]              out_ch_q;
  logic [CW-1:0]              rr_ptr_q;
  logic [CW-1:0]              grant_q;
  logic [BURST_CNT_W-1:0]     burst_cnt_q;

  logic [NUM_CH-1:0]          req;
  logic                       can_arb;
  logic                       in_burst;
  logic                       chan_dry;
  logic                       preempt;
  logic                       keep_burst;
  logic [CW-1:0]              grant_inc;
  logic [CW-1:0]              rr_ptr_d;
  logic [CW-1:0]              grant_d;
  logic [NUM_CH-1:0]          read_oh_d;
  logic [BURST_CNT_W-1:0]     burst_inc;
  logic [FIFO_DATA_WIDTH-1:0] cap_word;

  logic [NUM_CH-1:0]          norm_oh;
  logic [CW-1:0]              norm_idx;
  logic [NUM_CH-1:0]          pick_oh;
  logic [CW-1:0]              pick_idx;

  assign req       = ~ch_empty;
  assign can_arb   = (!out_valid_q || out_ready) && (|req);
  assign in_burst  = (burst_cnt_q != '0);
  // The burst count is cleared the moment it reaches BURST_LEN, so a non-zero
  // count always means the current channel still has burst budget left.
  assign chan_dry  = in_burst && ch_empty[grant_q];
  assign grant_inc = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + CW'(1);
  assign burst_inc = burst_cnt_q + BURST_CNT_W'(1);
  assign cap_word  = ch_read_data[int'(grant_q)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];

  assign keep_burst = in_burst && !chan_dry && !preempt;
  // An abandoned burst hands priority to the channel after the old grant.
  assign rr_ptr_d   = (in_burst && !keep_burst) ? grant_inc : rr_ptr_q;
  assign grant_d    = keep_burst ? grant_q : pick_idx;
  assign read_oh_d  = keep_burst ? (CH_ONE << grant_q) : pick_oh;

  rr_pick #(
    .N  (NUM_CH),
    .IW (CW)
  ) u_pick_norm (
    .req_i     (req),
    .ptr_i     (rr_ptr_d),
    .gnt_oh_o  (norm_oh),
    .gnt_idx_o (norm_idx)
  );

`ifdef FIFO_SCHED_URGENT_EN
  logic [NUM_CH-1:0] urg_req;
  logic              urg_any;
  logic [NUM_CH-1:0] urg_oh;
  logic [CW-1:0]     urg_idx;

  assign urg_req = req & ch_almost_full;
  // Taken from the request vector rather than the picker to keep the pointer path acyclic.
  assign urg_any = |urg_req;
  assign preempt = in_burst && urg_any && !urg_req[grant_q];

  rr_pick #(
    .N  (NUM_CH),
    .IW (CW)
  ) u_pick_urg (
    .req_i     (urg_req),
    .ptr_i     (rr_ptr_d),
    .gnt_oh_o  (urg_oh),
    .gnt_idx_o (urg_idx)
  );

  assign pick_oh  = urg_any ? urg_oh  : norm_oh;
  assign pick_idx = urg_any ? urg_idx : norm_idx;
`else
  assign preempt  = 1'b0;
  assign pick_oh  = norm_oh;
  assign pick_idx = norm_idx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_read_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      // Consumed word drops here; CAPTURE below overrides in the same cycle.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (can_arb) begin
            state_q   <= ST_ISSUE;
            grant_q   <= grant_d;
            ch_read_q <= read_oh_d;
            rr_ptr_q  <= rr_ptr_d;
            if (!keep_burst) begin
              burst_cnt_q <= '0;
            end
          end else if (chan_dry) begin
            rr_ptr_q    <= grant_inc;
            burst_cnt_q <= '0;
          end
        end

        ST_ISSUE: begin
          ch_read_q <= '0;
          state_q   <= ST_CAPTURE;
          if (burst_inc >= BURST_CNT_W'(BURST_LEN)) begin
            burst_cnt_q <= '0;
            rr_ptr_q    <= grant_inc;
          end else begin
            burst_cnt_q <= burst_inc;
          end
        end

        ST_CAPTURE: begin
          out_data_q  <= cap_word;
          out_ch_q    <= grant_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
          // The empty flag now reflects the pop, so an exhausted channel ends its burst here.
          if (chan_dry) begin
            rr_ptr_q    <= grant_inc;
            burst_cnt_q <= '0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          ch_read_q <= '0;
        end
      endcase
    end
  end

  assign ch_read   = ch_read_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of upstream FIFOs (2..16).
REQ-002 SHALL have parameter FIFO_DATA_WIDTH, default 8, word width.
REQ-003 SHALL have parameter BURST_LEN, default 2, maximum consecutive words per grant (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ch_empty  input  NUM_CH  empty flag per upstream FIFO.
REQ-007 SHALL have port ch_read_data  input  NUM_CH*FIFO_DATA_WIDTH  registered read_data of each FIFO; channel i occupies bits [i*W +: W].
REQ-008 SHALL have port ch_read  output  NUM_CH  registered one-hot read strobe to the FIFOs.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word; transfer when out_valid & out_ready.
REQ-011 SHALL have port out_data  output  FIFO_DATA_WIDTH  captured word.
REQ-012 SHALL have port out_ch  output  $clog2(NUM_CH)  source channel of out_data.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, CAPTURE.
REQ-014 IDLE: SHALL arbitrate only when (out_valid==0 or out_ready==1) and at least one ch_empty bit is 0; winner registered into grant; next state ISSUE; otherwise stay IDLE.
REQ-015 ISSUE: SHALL drive ch_read = one-hot(grant) for exactly one cycle; next state CAPTURE.
REQ-016 CAPTURE: SHALL latch ch_read_data[grant] into out_data, grant into out_ch, and set out_valid; next state IDLE.
REQ-017 Latency: SHALL make out_valid rise 3 cycles after the IDLE arbitration cycle; maximum throughput one word per 3 cycles.
REQ-018 out_valid SHALL clear on a transfer cycle unless CAPTURE sets it in the same cycle.
REQ-019 ch_read SHALL never be asserted to a channel whose ch_empty is 1 in the ISSUE cycle, and never to more than one channel at a time.
REQ-020 Arbitration: SHALL be round-robin from pointer rr_ptr; the lowest index >= rr_ptr (wrapping modulo NUM_CH) with ch_empty==0 wins.
REQ-021 Burst: while the current channel has issued fewer than BURST_LEN consecutive words and remains non-empty, it SHALL win again ahead of rr_ptr.
REQ-022 When a burst ends (count reaches BURST_LEN or the channel empties), rr_ptr SHALL become grant+1 modulo NUM_CH and the burst count SHALL clear.
REQ-023 With all channels empty, the block SHALL stay IDLE with no ch_read pulses; rr_ptr SHALL be unchanged.
REQ-024 With out_valid==1 and out_ready==0, the block SHALL hold out_data and out_ch stable and issue no new read.

Reset
REQ-025 Reset SHALL asynchronously force state IDLE, ch_read=0, out_valid=0, out_data=0, out_ch=0, rr_ptr=0, grant=0, burst count=0.
REQ-026 Reset asserted during ISSUE or CAPTURE SHALL discard the in-flight word; no out_valid SHALL result from it after reset release.

Configuration
REQ-027 With macro FIFO_SCHED_URGENT_EN defined, SHALL add input ch_almost_full (NUM_CH); any channel with ch_almost_full==1 and ch_empty==0 SHALL beat non-urgent channels, ties resolved round-robin from rr_ptr, and an urgent request SHALL terminate a non-urgent burst at its next arbitration.
REQ-028 Without FIFO_SCHED_URGENT_EN, the port SHALL be absent and arbitration SHALL be pure round-robin with bursts.

Structure
REQ-029 Shared package fifo_sched_pkg SHALL hold the FSM state encoding, the default NUM_CH/BURST_LEN constants, and the channel-index width function.
REQ-030 Sub-module rr_pick (combinational masked round-robin priority picker, request vector plus pointer in, one-hot and index out) SHALL be instantiated once, or twice with FIFO_SCHED_URGENT_EN.

Verification
REQ-031 Reset: assert reset mid-ISSUE -> ch_read=0, out_valid=0 immediately; no spurious word after release.
REQ-032 Round-robin: BURST_LEN=1, all 4 channels non-empty, out_ready=1 -> out_ch sequence 0,1,2,3,0.
REQ-033 Burst: BURST_LEN=2, channels 1 and 2 hold 3 words each -> out_ch 1,1,2,2,1,2.
REQ-034 Backpressure: out_ready=0 for 10 cycles with word 0xA5 from channel 3 -> out_data=0xA5, out_ch=3 stable, no ch_read pulse; single transfer when out_ready=1.
REQ-035 Empty boundary: only channel 2 holds one word -> exactly one ch_read pulse to channel 2, then IDLE with no reads; rr_ptr=3.
REQ-036 Urgent (FIFO_SCHED_URGENT_EN): channels 0 and 3 non-empty, ch_almost_full[3]=1, rr_ptr=0 -> out_ch=3 first.
